elementwise_mult_sched: RTL

- Round-robin scheduler that shares one N-bit unsigned multiplier between two requesters.
- Each requester submits LEN-element operand vectors; the block processes one element per cycle, then returns the product vector tagged with the requester id.
- Sits between client blocks and the sequential elementwise multiply datapath, adding handshake, arbitration and cycle accounting.

---
 rtl/elementwise_mult_sched.sv | 93 +++++++++
 1 files changed

// File: rtl/elementwise_mult_sched.sv
// elementwise_mult_sched: round-robin share of one NxN multiplier between two vector requesters
module elementwise_mult_sched #(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [LEN*N-1:0]     req0_a,
    input  logic [LEN*N-1:0]     req0_b,
    input  logic [LEN*N-1:0]     req1_a,
    input  logic [LEN*N-1:0]     req1_b,
    output logic [1:0]           req_ack,
    output logic                 busy,
    output logic                 mult_pulse,
    output logic [LEN*2*N-1:0]   result,
    output logic                 result_valid,
    output logic                 result_id,
    output logic [7:0]           job_cycles
);
    localparam int IW = $clog2(LEN);
    typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic grant, last_grant, pick, last;
    logic [LEN*N-1:0] a_reg, b_reg;
    logic [LEN*2*N-1:0] acc, acc_nx;
    logic [N-1:0] ae, be;
    logic [2*N-1:0] prod;
    logic [7:0] cyc;
    // Arbitration, next state, handshake outputs and the current element product
    always_comb begin
        pick = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        last = (idx == IW'(LEN - 1));
        state_nx = state;
        case (state)
            IDLE: state_nx = |req_valid ? LOAD : IDLE;
            LOAD: state_nx = MULT;
            MULT: state_nx = last ? DONE : MULT;
            DONE: state_nx = IDLE;
        endcase
        busy = (state != IDLE);
        mult_pulse = (state == MULT);
        result_valid = (state == DONE);
        req_ack = (state == LOAD) ? {grant, ~grant} : 2'b00;
        ae = a_reg[idx*N +: N];
        be = b_reg[idx*N +: N];
        prod = {{N{1'b0}}, ae} * {{N{1'b0}}, be};
        acc_nx = acc;
        acc_nx[idx*2*N +: 2*N] = prod;
    end
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Grant bookkeeping, operand capture, per-element products and the held job outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant <= 1'b0;
            last_grant <= 1'b1;
            a_reg <= '0;
            b_reg <= '0;
            acc <= '0;
            idx <= '0;
            cyc <= '0;
            result <= '0;
            result_id <= 1'b0;
            job_cycles <= '0;
        end else begin
            if (state == IDLE && |req_valid) begin
                grant <= pick;
                last_grant <= pick;
            end
            if (state == LOAD) begin
                a_reg <= grant ? req1_a : req0_a;
                b_reg <= grant ? req1_b : req0_b;
                idx <= '0;
                cyc <= 8'd1;
            end
            if (state == MULT) begin
                acc <= acc_nx;
                idx <= last ? '0 : idx + IW'(1);
                cyc <= cyc + 8'd1;
                if (last) begin
                    result <= acc_nx;
                    result_id <= grant;
                    job_cycles <= cyc + 8'd2;
                end
            end
        end
    end
endmodule
